// File: rtl/alu_seq_unit.sv
// Multi-cycle ALU responder. Add and subtract finish in one cycle; multiply and divide take WIDTH cycles.
// Optional feature macro: ALU_DIVZERO_TRAP_EN adds the div_by_zero output and a zero result on divide by zero.
module alu_seq_unit #(
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Carry,
  output logic             OverFlow,
  output logic             Zero,
  output logic             Negative
`ifdef ALU_DIVZERO_TRAP_EN
  ,
  output logic             div_by_zero
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, hi_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q, ovf_q, zero_q, neg_q, out_valid_q, dz_q;

  logic [WIDTH:0]   add_w, sub_w, mul_sum, div_sh, div_sub;
  logic [WIDTH-1:0] mul_hi, mul_lo, div_rem, div_quo;
  logic             div_ge, last, accept, b_zero;
  logic [WIDTH-1:0] res_d;
  logic             c_d, v_d, load;

  assign add_w   = {1'b0, A} + {1'b0, B};
  assign sub_w   = {1'b0, A} - {1'b0, B};
  assign b_zero  = (B == '0);
  assign accept  = in_valid && (state_q == S_IDLE);
  assign last    = (cnt_q == CW'(WIDTH - 1));

  // Multiply: {hi_q, b_q} is the product register; multiplier bits shift out of b_q's LSB.
  assign mul_sum = {1'b0, hi_q} + (b_q[0] ? {1'b0, a_q} : '0);
  assign mul_hi  = mul_sum[WIDTH:1];
  assign mul_lo  = {mul_sum[0], b_q[WIDTH-1:1]};

  // Restoring divide: hi_q holds the remainder, quotient bits shift into a_q as the dividend leaves it.
  assign div_sh  = {hi_q, a_q[WIDTH-1]};
  assign div_sub = div_sh - {1'b0, b_q};
  assign div_ge  = (div_sh >= {1'b0, b_q});
  assign div_rem = div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0];
  assign div_quo = {a_q[WIDTH-2:0], div_ge};

  always_comb begin
    res_d = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    load  = 1'b0;
    case (state_q)
      S_IDLE: begin
        case (ALUControl)
          2'b00: begin
            res_d = add_w[WIDTH-1:0];
            c_d   = add_w[WIDTH];
            v_d   = (A[WIDTH-1] == B[WIDTH-1]) && (add_w[WIDTH-1] != A[WIDTH-1]);
            load  = accept;
          end
          2'b01: begin
            res_d = sub_w[WIDTH-1:0];
            c_d   = ~sub_w[WIDTH];
            v_d   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_w[WIDTH-1] != A[WIDTH-1]);
            load  = accept;
          end
          2'b11: begin
`ifdef ALU_DIVZERO_TRAP_EN
            res_d = '0;
`else
            res_d = '1;
`endif
            v_d   = 1'b1;
            load  = accept && b_zero;
          end
          default: ;
        endcase
      end
      S_MUL: begin
        res_d = mul_lo;
        c_d   = |mul_hi;
        v_d   = |mul_hi;
        load  = last;
      end
      S_DIV: begin
        res_d = div_quo;
        load  = last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      hi_q        <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      if (load) begin
        result_q    <= res_d;
        carry_q     <= c_d;
        ovf_q       <= v_d;
        zero_q      <= (res_d == '0);
        neg_q       <= res_d[WIDTH-1];
        out_valid_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: if (accept) begin
          a_q   <= A;
          b_q   <= B;
          hi_q  <= '0;
          cnt_q <= '0;
          case (ALUControl)
            2'b10:   state_q <= S_MUL;
            2'b11: begin
              state_q <= b_zero ? S_DONE : S_DIV;
              dz_q    <= b_zero;
            end
            default: state_q <= S_DONE;
          endcase
        end
        S_MUL: begin
          hi_q  <= mul_hi;
          b_q   <= mul_lo;
          cnt_q <= cnt_q + CW'(1);
          if (last) state_q <= S_DONE;
        end
        S_DIV: begin
          hi_q  <= div_rem;
          a_q   <= div_quo;
          cnt_q <= cnt_q + CW'(1);
          if (last) state_q <= S_DONE;
        end
        S_DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          dz_q        <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign Result    = result_q;
  assign Carry     = carry_q;
  assign OverFlow  = ovf_q;
  assign Zero      = zero_q;
  assign Negative  = neg_q;
`ifdef ALU_DIVZERO_TRAP_EN
  assign div_by_zero = dz_q;
`else
  logic unused_dz;
  assign unused_dz = dz_q;
`endif

endmodule
